// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 round-key schedule sequencer with shared S-box arbitration
module aes_key_sched_ctrl #(
    parameter int          NUM_RND   = 10,
    parameter logic [7:0]  RCON_INIT = 8'h01,
    parameter int          SBOX_LAT  = 1,
    parameter int          MAX_WAIT  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_rk_ready,
    input  logic       i_sbox_dp_req,
    output logic       o_sbox_dp_gnt,
    output logic       o_sbox_kg_gnt,
    output logic       o_gen_key,
    output logic       o_next_rnd,
    output logic [7:0] o_r_con,
    output logic [3:0] o_rnd_idx,
    output logic       o_rk_valid,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PRESENT, S_REQ_SBOX, S_SUB_WAIT, S_EXPAND, S_DONE
    } state_t;

    localparam logic [3:0] LAST_RND  = 4'(NUM_RND);
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);
    localparam logic [1:0] LAT_LAST  = 2'(SBOX_LAT - 1);

    state_t     r_state;
    logic [7:0] r_con;
    logic [3:0] r_rnd_idx;
    logic [3:0] r_wait_cnt;
    logic [1:0] r_lat_cnt;
    logic       r_gen_key;
    logic       r_next_rnd;
    logic       r_rk_valid;
    logic       r_kg_gnt;
    logic       r_busy;
    logic       r_done;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Flag registers hold the value belonging to the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rst || (i_abort && r_state != S_IDLE)) begin
            r_state    <= S_IDLE;
            r_con      <= RCON_INIT;
            r_rnd_idx  <= '0;
            r_wait_cnt <= '0;
            r_lat_cnt  <= '0;
            r_gen_key  <= 1'b0;
            r_next_rnd <= 1'b0;
            r_rk_valid <= 1'b0;
            r_kg_gnt   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_gen_key  <= 1'b0;
            r_next_rnd <= 1'b0;
            r_done     <= 1'b0;
            r_rk_valid <= 1'b0;
            r_kg_gnt   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_con     <= RCON_INIT;
                    r_rnd_idx <= '0;
                    if (i_start && !i_abort) begin
                        r_state   <= S_LOAD;
                        r_gen_key <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_PRESENT;
                    r_rk_valid <= 1'b1;
                end
                S_PRESENT: begin
                    if (i_rk_ready) begin
                        if (r_rnd_idx == LAST_RND) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_REQ_SBOX;
                        end
                    end else begin
                        r_rk_valid <= 1'b1;
                    end
                end
                S_REQ_SBOX: begin
                    // Defer to the datapath, but never longer than MAX_WAIT cycles.
                    if (!i_sbox_dp_req || r_wait_cnt == WAIT_LAST) begin
                        r_wait_cnt <= '0;
                        r_lat_cnt  <= '0;
                        r_state    <= S_SUB_WAIT;
                        r_kg_gnt   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_SUB_WAIT: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_state    <= S_EXPAND;
                        r_next_rnd <= 1'b1;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                        r_kg_gnt  <= 1'b1;
                    end
                end
                S_EXPAND: begin
                    r_rnd_idx  <= r_rnd_idx + 4'd1;
                    r_con      <= xtime(r_con);
                    r_state    <= S_PRESENT;
                    r_rk_valid <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Abort must silence pulses and grants in the very cycle it is raised.
    assign o_gen_key     = r_gen_key  & ~i_abort;
    assign o_next_rnd    = r_next_rnd & ~i_abort;
    assign o_rk_valid    = r_rk_valid & ~i_abort;
    assign o_sbox_kg_gnt = r_kg_gnt   & ~i_abort;
    assign o_done        = r_done     & ~i_abort;
    assign o_sbox_dp_gnt = i_sbox_dp_req & (r_state != S_SUB_WAIT);
    assign o_busy        = r_busy;
    assign o_r_con       = r_con;
    assign o_rnd_idx     = r_rnd_idx;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - directed and randomized bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, rk_ready, dp_req;
    logic a_dg, a_kg, a_gk, a_nr, a_rv, a_bz, a_dn;
    logic b_dg, b_kg, b_gk, b_nr, b_rv, b_bz, b_dn;
    logic [7:0] a_rc, b_rc;
    logic [3:0] a_ri, b_ri;

    aes_key_sched_ctrl u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_rk_ready(rk_ready), .i_sbox_dp_req(dp_req),
        .o_sbox_dp_gnt(a_dg), .o_sbox_kg_gnt(a_kg), .o_gen_key(a_gk),
        .o_next_rnd(a_nr), .o_r_con(a_rc), .o_rnd_idx(a_ri),
        .o_rk_valid(a_rv), .o_busy(a_bz), .o_done(a_dn)
    );

    aes_key_sched_ctrl #(.SBOX_LAT(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_rk_ready(rk_ready), .i_sbox_dp_req(dp_req),
        .o_sbox_dp_gnt(b_dg), .o_sbox_kg_gnt(b_kg), .o_gen_key(b_gk),
        .o_next_rnd(b_nr), .o_r_con(b_rc), .o_rnd_idx(b_ri),
        .o_rk_valid(b_rv), .o_busy(b_bz), .o_done(b_dn)
    );

    localparam int NUM_RND = 10;
    localparam int MAX_WAIT = 4;
    localparam int P_IDLE = 0, P_LOAD = 1, P_PRES = 2, P_REQ = 3, P_SUB = 4, P_EXP = 5, P_DONE = 6;

    int m_ph[2];
    int m_rnd[2];
    int m_age[2];
    int lat_of[2] = '{1, 3};

    int n_pass = 0;
    int n_tot = 0;
    int k_run = 0;
    int a_done_at, b_done_at, a_idle_at, a_gk_n, a_rv_n, a_nr_first, hold;
    logic [7:0] rc_q[$];

    // Round constant for round r: 2^(r-1) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] rcon_of(input int r);
        int x;
        x = 1;
        for (int n = 1; n < r; n++) begin
            x = x * 2;
            if (x >= 256) x = x ^ 'h11b;
        end
        return 8'(x);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (run cycle %0d)", tag, obs, exp, k_run);
    endtask

    task automatic check_inst(input int i, input string nm, input logic [7:0] rc, input logic [3:0] ri,
                              input logic gk, input logic nr, input logic rv, input logic kg,
                              input logic dg, input logic bz, input logic dn);
        int ph;
        logic live;
        ph = m_ph[i];
        live = !abort;
        chk({nm, ".busy"},     32'(bz), 32'(ph != P_IDLE));
        chk({nm, ".gen_key"},  32'(gk), 32'(ph == P_LOAD && live));
        chk({nm, ".rk_valid"}, 32'(rv), 32'(ph == P_PRES && live));
        chk({nm, ".kg_gnt"},   32'(kg), 32'(ph == P_SUB && live));
        chk({nm, ".dp_gnt"},   32'(dg), 32'(dp_req && ph != P_SUB));
        chk({nm, ".next_rnd"}, 32'(nr), 32'(ph == P_EXP && live));
        chk({nm, ".done"},     32'(dn), 32'(ph == P_DONE && live));
        chk({nm, ".rnd_idx"},  32'(ri), 32'(m_rnd[i]));
        chk({nm, ".r_con"},    32'(rc), 32'(rcon_of(m_rnd[i] + 1)));
        chk({nm, ".overlap"},  32'(kg & dg), 32'd0);
    endtask

    task automatic advance();
        for (int i = 0; i < 2; i++) begin
            int nph;
            nph = m_ph[i];
            if (rst || (abort && m_ph[i] != P_IDLE)) begin
                m_ph[i] = P_IDLE;
                m_rnd[i] = 0;
                m_age[i] = 0;
            end else begin
                case (m_ph[i])
                    P_IDLE: begin
                        m_rnd[i] = 0;
                        if (start && !abort) nph = P_LOAD;
                    end
                    P_LOAD: nph = P_PRES;
                    P_PRES: if (rk_ready) nph = (m_rnd[i] == NUM_RND) ? P_DONE : P_REQ;
                    P_REQ:  if (!dp_req || m_age[i] == MAX_WAIT - 1) nph = P_SUB;
                    P_SUB:  if (m_age[i] == lat_of[i] - 1) nph = P_EXP;
                    P_EXP: begin
                        m_rnd[i] = m_rnd[i] + 1;
                        nph = P_PRES;
                    end
                    default: nph = P_IDLE;
                endcase
                m_age[i] = (nph == m_ph[i]) ? m_age[i] + 1 : 0;
                m_ph[i] = nph;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_inst(0, "a", a_rc, a_ri, a_gk, a_nr, a_rv, a_kg, a_dg, a_bz, a_dn);
        check_inst(1, "b", b_rc, b_ri, b_gk, b_nr, b_rv, b_kg, b_dg, b_bz, b_dn);
        if (a_dn && a_done_at < 0) a_done_at = k_run;
        if (b_dn && b_done_at < 0) b_done_at = k_run;
        if (!a_bz && k_run > 0 && a_idle_at < 0) a_idle_at = k_run;
        if (a_gk) a_gk_n++;
        if (a_rv) a_rv_n++;
        if (a_nr) begin
            rc_q.push_back(a_rc);
            if (a_nr_first < 0) a_nr_first = k_run;
        end
        @(posedge clk);
        advance();
        k_run++;
        #1;
    endtask

    // mode: 0 nominal, 1 backpressure, 2 starvation, 3 random, 4 abort, 5 reset, 6 start while busy
    task automatic run_sched(input int mode, input int budget);
        k_run = 0; a_done_at = -1; b_done_at = -1; a_idle_at = -1;
        a_gk_n = 0; a_rv_n = 0; a_nr_first = -1; hold = 0;
        rc_q.delete();
        rst = 0; abort = 0; start = 1; rk_ready = 1; dp_req = (mode == 2);
        step();
        while (m_ph[0] != P_IDLE || m_ph[1] != P_IDLE) begin
            if (k_run > budget) begin
                n_tot++;
                $error("FAIL timeout: mode %0d still busy after %0d cycles", mode, k_run);
                break;
            end
            rst = 0; abort = 0; start = 0; rk_ready = 1; dp_req = (mode == 2);
            case (mode)
                1: if (m_ph[0] == P_PRES && m_rnd[0] == 3 && hold < 5) begin
                       rk_ready = 0;
                       hold++;
                   end
                3: begin
                       rk_ready = ($urandom % 4) != 0;
                       dp_req = 1'($urandom % 2);
                       abort = (k_run > 2) && (($urandom % 150) == 0);
                       start = (m_ph[0] != P_IDLE && m_ph[1] != P_IDLE) && (($urandom % 8) == 0);
                   end
                4: if (m_ph[0] == P_SUB && m_rnd[0] == 6) abort = 1;
                5: if (k_run == 20) rst = 1;
                6: if (k_run == 10 || k_run == 30) start = 1;
                default: ;
            endcase
            step();
        end
        rst = 0; abort = 0; start = 0; rk_ready = 1; dp_req = 0;
    endtask

    initial begin
        logic [7:0] exp_rc [10];
        exp_rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        rst = 1; start = 0; abort = 0; rk_ready = 0; dp_req = 0;
        a_done_at = -1; b_done_at = -1; a_idle_at = -1; a_gk_n = 0; a_rv_n = 0; a_nr_first = -1; hold = 0;
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = P_IDLE; m_rnd[i] = 0; m_age[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("reset.r_con", 32'(a_rc), 32'h01);
        chk("reset.busy", 32'(a_bz), 32'd0);
        rst = 0;

        run_sched(0, 200);
        chk("nominal.gen_key_count", a_gk_n, 1);
        chk("nominal.rk_valid_count", a_rv_n, 11);
        chk("nominal.first_next_rnd", a_nr_first, 5);
        chk("nominal.done_cycle", a_done_at, 43);
        chk("nominal.busy_drop", a_idle_at, 44);
        chk("lat3.done_cycle", b_done_at, 63);
        chk("nominal.rcon_count", rc_q.size(), 10);
        for (int i = 0; i < 10 && i < rc_q.size(); i++) chk("nominal.rcon_seq", 32'(rc_q[i]), 32'(exp_rc[i]));

        run_sched(1, 200);
        chk("backpressure.done_cycle", a_done_at, 48);

        run_sched(2, 300);
        chk("starve.done_cycle", a_done_at, 73);
        chk("starve.lat3_done_cycle", b_done_at, 93);

        run_sched(4, 200);
        chk("abort.busy", 32'(a_bz), 32'd0);
        chk("abort.r_con", 32'(a_rc), 32'h01);
        chk("abort.rnd_idx", 32'(a_ri), 32'd0);
        chk("abort.next_rnd", 32'(a_nr), 32'd0);
        chk("abort.done_seen", a_done_at, -1);

        run_sched(0, 200);
        chk("rerun.done_cycle", a_done_at, 43);
        chk("rerun.first_rcon", rc_q.size() > 0 ? 32'(rc_q[0]) : 32'hffff, 32'h01);

        run_sched(5, 200);
        chk("reset_mid.busy", 32'(a_bz), 32'd0);
        chk("reset_mid.r_con", 32'(a_rc), 32'h01);
        chk("reset_mid.rk_valid", 32'(a_rv), 32'd0);
        chk("reset_mid.kg_gnt", 32'(b_kg), 32'd0);

        run_sched(6, 200);
        chk("busy_start.gen_key_count", a_gk_n, 1);
        chk("busy_start.done_cycle", a_done_at, 43);

        start = 1; abort = 1;
        step();
        chk("abort_start_idle.busy", 32'(a_bz), 32'd0);
        chk("abort_start_idle.gen_key", 32'(a_gk), 32'd0);
        start = 0; abort = 0;

        for (int r = 0; r < 8; r++) run_sched(3, 3000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
